// File: rtl/vector_stim_checker.sv
// On-chip vector sweeper: drives every input pattern into a small DUT
// and checks its response against a truth table.
module vector_stim_checker #(
    parameter int                   N_IN     = 3,
    parameter logic [2**N_IN-1:0]   EXPECTED = 8'b0011_0001,
    parameter int                   SETTLE   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            resp,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        FINISH
    } state_t;

    localparam logic [N_IN-1:0] LAST_VEC    = '1;
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic       miss;

    assign miss = (resp != EXPECTED[stim]);
    assign pass = done && (err_count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) state_next = DRIVE;
            end
            DRIVE: begin
                if (settle_cnt == SETTLE_LAST) state_next = CHECK;
            end
            CHECK: begin
                if (stim == LAST_VEC) state_next = FINISH;
                else                  state_next = DRIVE;
            end
            FINISH: begin
                if (start) state_next = DRIVE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are cleared on the accepting edge so a restart from
    // FINISH behaves exactly like a start from IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            settle_cnt       <= '0;
        end else begin
            unique case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        stim             <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                        settle_cnt       <= '0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                CHECK: begin
                    if (miss) begin
                        err_count <= err_count + (N_IN+1)'(1);
                        if (!first_fail_valid) begin
                            first_fail_vec   <= stim;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (stim == LAST_VEC) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        stim       <= stim + (N_IN)'(1);
                        settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
